// File: rtl/i2c_scl_gen_pkg.sv
`timescale 1ns/1ps
// rtl/i2c_scl_gen_pkg.sv - shared I2C SCL phase encodings
// Bit and byte controllers decode these states to follow SCL phase.
package i2c_scl_gen_pkg;

  typedef enum logic [2:0] {
    SCL_IDLE  = 3'd0,
    SCL_LOW1  = 3'd1,
    SCL_LOW2  = 3'd2,
    SCL_HIGH1 = 3'd3,
    SCL_HIGH2 = 3'd4
  } scl_state_e;

  function automatic logic scl_drives_low(input scl_state_e s);
    return (s == SCL_LOW1) || (s == SCL_LOW2);
  endfunction

endpackage

// File: rtl/counter_param.sv
`timescale 1ns/1ps
// rtl/counter_param.sv - parameterized up-counter with synchronous clear
// Clear has priority over count_up.
module counter_param #(
  parameter int counter_width = 8
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     clear,
  input  logic                     count_up,
  output logic [counter_width-1:0] count
);

  localparam logic [counter_width-1:0] cnt_one = counter_width'(1);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_up) begin
      count <= count + cnt_one;
    end
  end

endmodule

// File: rtl/i2c_scl_gen.sv
`timescale 1ns/1ps
// rtl/i2c_scl_gen.sv - I2C master SCL phase generator with clock stretching
// Four quarters per bit; strobes mark SDA change, sample and bit end.
module i2c_scl_gen
  import i2c_scl_gen_pkg::*;
#(
  parameter int div_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 enable,
  input  logic [div_width-1:0] quarter_div,
  input  logic                 scl_in,
  output logic                 scl_oe,
  output logic                 busy,
  output logic                 chg_stb,
  output logic                 smp_stb,
  output logic                 bit_done,
  output logic                 stretch
);

  scl_state_e           state, next_state;
  logic                 sync1, scl_sync;
  logic [div_width-1:0] q_reg;
  logic [div_width-1:0] count;
  logic                 cnt_en, qend;
  logic                 chg_nxt, smp_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync1    <= 1'b1;
      scl_sync <= 1'b1;
    end else begin
      sync1    <= scl_in;
      scl_sync <= sync1;
    end
  end

  // HIGH1 only counts once the released line is actually seen high.
  assign cnt_en = (state == SCL_LOW1) || (state == SCL_LOW2) || (state == SCL_HIGH2) ||
                  ((state == SCL_HIGH1) && scl_sync);
  assign qend   = cnt_en && (count == q_reg);

  counter_param #(
    .counter_width(div_width)
  ) quarter_cnt (
    .clk     (clk),
    .rst_    (rst_),
    .clear   (qend || (state == SCL_IDLE)),
    .count_up(cnt_en),
    .count   (count)
  );

  always_comb begin
    next_state = state;
    chg_nxt    = 1'b0;
    smp_nxt    = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      SCL_IDLE:  if (enable) next_state = SCL_LOW1;
      SCL_LOW1:  if (qend) begin
                   next_state = SCL_LOW2;
                   chg_nxt    = 1'b1;
                 end
      SCL_LOW2:  if (qend) next_state = SCL_HIGH1;
      SCL_HIGH1: if (qend) begin
                   next_state = SCL_HIGH2;
                   smp_nxt    = 1'b1;
                 end
      SCL_HIGH2: if (qend) begin
                   next_state = enable ? SCL_LOW1 : SCL_IDLE;
                   done_nxt   = 1'b1;
                 end
      default:   next_state = SCL_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= SCL_IDLE;
      q_reg    <= '0;
      scl_oe   <= 1'b0;
      busy     <= 1'b0;
      chg_stb  <= 1'b0;
      smp_stb  <= 1'b0;
      bit_done <= 1'b0;
      stretch  <= 1'b0;
    end else begin
      state    <= next_state;
      if ((state == SCL_IDLE) && enable) q_reg <= quarter_div;
      scl_oe   <= scl_drives_low(next_state);
      busy     <= (next_state != SCL_IDLE);
      chg_stb  <= chg_nxt;
      smp_stb  <= smp_nxt;
      bit_done <= done_nxt;
      stretch  <= (next_state == SCL_HIGH1) && !sync1;
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
`timescale 1ns/1ps
// tb/tb_i2c_scl_gen.sv - scoreboard bench for i2c_scl_gen
module tb_i2c_scl_gen;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  logic       clk = 1'b0;
  logic       rst_;
  logic       enable;
  logic [7:0] quarter_div;
  logic       scl_in;
  logic       hold = 1'b0;
  logic       arm = 1'b0;
  logic       prev_oe = 1'b0;
  int         hold_cnt = 0;
  logic       scl_oe, busy, chg_stb, smp_stb, bit_done, stretch;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  i2c_scl_gen #(.div_width(8)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .enable     (enable),
    .quarter_div(quarter_div),
    .scl_in     (scl_in),
    .scl_oe     (scl_oe),
    .busy       (busy),
    .chg_stb    (chg_stb),
    .smp_stb    (smp_stb),
    .bit_done   (bit_done),
    .stretch    (stretch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain bus: low if master drives or slave stretches.
  assign scl_in = !scl_oe && !hold;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // b = first LOW1 cycle, q = quarter_div, s = extra stretch cycles
  task automatic push_bit(input int b, input int q, input int s);
    push(0, b + q + 1);
    push(1, b + 3*q + 5 + s);
    push(2, b + 4*q + 6 + s);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_strobe", kind, -1);
    end else begin
      e = sb.pop_front();
      check("strobe_kind", kind, e.kind);
      check("strobe_cycle", cyc, e.cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    int nhi;
    nhi = int'(chg_stb) + int'(smp_stb) + int'(bit_done);
    if (nhi > 0) check("strobe_overlap", nhi, 1);
    if (chg_stb)  pop_check(0);
    if (smp_stb)  pop_check(1);
    if (bit_done) pop_check(2);
  end

  // Slave model: hold SCL low for 20 cycles after the next release when armed.
  always @(negedge clk) begin : slave
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) hold = 1'b0;
    end else if (arm && !scl_oe && prev_oe) begin
      hold     = 1'b1;
      hold_cnt = 20;
      arm      = 1'b0;
    end
    prev_oe = scl_oe;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int b, n;
    logic oe_bad;
    rst_        = 1'b0;
    enable      = 1'b0;
    quarter_div = 8'd3;
    repeat (3) @(negedge clk);
    check("reset_scl_oe", scl_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_stretch", stretch, 0);
    check("reset_strobes", int'(chg_stb) + int'(smp_stb) + int'(bit_done), 0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);

    // Phase A: q=3, normal bit, stretched bit, enable drops in third bit
    enable = 1'b1;
    b = cyc + 1;
    push_bit(b, 3, 0);
    push_bit(b + 18, 3, 20);
    push_bit(b + 56, 3, 0);
    wait_cyc(b);
    quarter_div = 8'd7;
    check("busy_after_start", busy, 1);
    n = 0;
    while (scl_oe && n < 200) begin n++; @(negedge clk); end
    check("oe_drive_len", n, 8);
    n = 0;
    while (!scl_oe && n < 200) begin n++; @(negedge clk); end
    check("oe_release_len", n, 10);
    arm = 1'b1;
    n = 0;
    while (!stretch && n < 100) begin n++; @(negedge clk); end
    n = 0;
    oe_bad = 1'b0;
    while (stretch && n < 200) begin
      if (scl_oe) oe_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("stretch_len", n, 22);
    check("stretch_oe", oe_bad, 0);
    wait_cyc(b + 57);
    enable = 1'b0;
    wait_cyc(b + 74);
    check("idle_busy_a", busy, 0);
    check("idle_oe_a", scl_oe, 0);
    wait_cyc(b + 76);
    check("pending_a", sb.size(), 0);

    // Phase B: q=7 loaded at this IDLE exit; mid-bit change to 0 ignored
    @(negedge clk);
    enable = 1'b1;
    b = cyc + 1;
    push_bit(b, 7, 0);
    push_bit(b + 34, 7, 0);
    wait_cyc(b + 2);
    quarter_div = 8'd0;
    wait_cyc(b + 35);
    enable = 1'b0;
    wait_cyc(b + 70);
    check("idle_busy_b", busy, 0);
    check("pending_b", sb.size(), 0);

    // Phase C: q=0, three back-to-back 6-cycle bits
    @(negedge clk);
    enable = 1'b1;
    b = cyc + 1;
    push_bit(b, 0, 0);
    push_bit(b + 6, 0, 0);
    push_bit(b + 12, 0, 0);
    wait_cyc(b + 13);
    enable = 1'b0;
    wait_cyc(b + 20);
    check("idle_busy_c", busy, 0);
    check("pending_c", sb.size(), 0);

    // Phase D: reset asserted during HIGH1
    quarter_div = 8'd3;
    @(negedge clk);
    enable = 1'b1;
    b = cyc + 1;
    push(0, b + 4);
    wait_cyc(b + 10);
    check("busy_before_rst", busy, 1);
    rst_   = 1'b0;
    enable = 1'b0;
    #1;
    check("rst_scl_oe", scl_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_stretch", stretch, 0);
    check("rst_strobes", int'(chg_stb) + int'(smp_stb) + int'(bit_done), 0);
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy_d", busy, 0);
    check("pending_d", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

I2C master SCL phase generator. Divides `clk` into four equal quarter-periods per bit, drives the open-drain SCL enable, and honours slave clock stretching. It emits single-cycle strobes for the shift/bit-control logic: data-change point, sample point and bit completion. The cycle counting in each quarter is done by the codebase's parameterized counter.

## Interface
- `div_width`, default 8. Width of the quarter-period divider and the internal counter.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_`  in  1  asynchronous reset, active low.
- `enable`  in  1  request to generate SCL bits continuously while high.
- `quarter_div`  in  `div_width`  quarter-period length minus 1, in `clk` cycles.
- `scl_in`  in  1  raw SCL line level. It is asynchronous and is synchronized internally.
- `scl_oe`  out  1  when 1, pull SCL low; when 0, release SCL.
- `busy`  out  1  high in any state except IDLE.
- `chg_stb`  out  1  one-cycle pulse at mid-low, where SDA may change.
- `smp_stb`  out  1  one-cycle pulse at mid-high, where SDA is sampled.
- `bit_done`  out  1  one-cycle pulse at the end of each bit.
- `stretch`  out  1  high while SCL has been released but is not yet seen high.

## Operation
- States and their `scl_oe` values:
  - IDLE: released
  - LOW1: low
  - LOW2: low
  - HIGH1: released
  - HIGH2: released
- Reset values:
  - state = IDLE, counter = 0, `q_reg` = 0.
  - Synchronizer flops = 1.
  - All outputs = 0.
- Synchronizer: two flops on `scl_in`, giving `scl_sync`.
- Quarter length:
  - `q_reg` is loaded from `quarter_div` on the IDLE→LOW1 transition only.
  - Changes to `quarter_div` while busy are ignored.
  - `quarter_div` = 0 gives a 1-cycle quarter.
- Count enable:
  - 1 in LOW1, LOW2 and HIGH2.
  - In HIGH1, it is 1 only when `scl_sync` = 1.
  - Held at 0 in IDLE.
- Quarter end (`qend`): count enable && counter == `q_reg`. On `qend` the counter is cleared synchronously; otherwise it increments.
- Transitions:
  - IDLE→LOW1 when `enable` = 1.
  - LOW1→LOW2 on `qend`; pulse `chg_stb`.
  - LOW2→HIGH1 on `qend`.
  - HIGH1→HIGH2 on `qend`; pulse `smp_stb`.
  - HIGH2 on `qend`: pulse `bit_done`, then go to LOW1 if `enable` = 1, else IDLE.
- `enable` falling mid-bit has no effect until HIGH2 ends; the bit always completes. IDLE leaves SCL released, which is the STOP/idle level.
- `stretch` = (state == HIGH1) && !`scl_sync`. It includes the 2-cycle synchronizer latency.
- A stretch has no timeout; the block waits in HIGH1 indefinitely.
- Asserting `rst_` mid-bit forces IDLE and released SCL immediately, with no strobe.

## Timing
- All outputs are registered and change on the rising edge of `clk`.
- Each strobe is high for exactly one cycle, in the cycle after the `qend` edge.
- LOW1, LOW2 and HIGH2 last `q_reg`+1 cycles each.
- HIGH1 with no external stretch lasts `q_reg`+3 cycles: 2 cycles of synchronizer latency plus `q_reg`+1.
- Bit period = 4·(`q_reg`+1)+2 cycles.
- `scl_oe` rises in the cycle after the edge at which `enable` is seen in IDLE.
- Back-to-back bits have no idle gap: `bit_done` and the HIGH2→LOW1 transition share the same edge.

## Structure
- State encodings for IDLE, LOW1, LOW2, HIGH1 and HIGH2 go in the shared I2C constants package, so bit and byte controllers can decode them.
- One sub-module: `counter_param` instance `quarter_cnt`, with these connections:
  - `counter_width` = `div_width`
  - `count_up` = count enable
  - `clear` = `qend` || (state == IDLE)
- The FSM, synchronizer and strobe registers are in this module.

## Test plan
- Reset, then `enable` = 1 with `quarter_div` = 3 and the bus modelled as line = !`scl_oe`:
  - `scl_oe` is low 8 cycles, high 10 cycles.
  - `chg_stb` occurs 4 cycles after LOW1 entry, `smp_stb` 6 cycles after HIGH1 entry.
  - Bit period is 18 cycles.
- Slave holds SCL low for 20 cycles after release:
  - `stretch` is high for 22 cycles.
  - `smp_stb` is delayed by exactly 20 cycles.
  - `scl_oe` stays 0 throughout.
- `enable` drops during LOW1 of the third bit:
  - The third bit completes with `bit_done`.
  - Then IDLE, with `scl_oe` = 0 and `busy` = 0.
- `quarter_div` changes from 3 to 7 mid-bit: no effect until the next IDLE exit, after which the bit period is 34 cycles.
- `quarter_div` = 0: bit period is 6 cycles, and the strobes never overlap.
- `rst_` asserted in HIGH1: all outputs are 0 immediately, and no strobe is emitted after release.
